// File: rtl/tmb_clk_pkg.sv
// Shared constants and helpers for the TMB emulator clock dividers.
package tmb_clk_pkg;

    // Channel output style selected by the per-channel mode bit
    localparam logic MODE_SQUARE = 1'b0;
    localparam logic MODE_STROBE = 1'b1;

    // Smallest divisor that still yields a distinguishable high and low phase
    localparam int MIN_DIV_DEF = 2;

    // Base clock frequency; LED and sync divisors are derived from it
    localparam int BASE_FREQ_HZ = 40_000_000;

    // Divisor that turns the base clock into the requested output frequency
    function automatic int hz_to_div(input int freq_hz);
        return BASE_FREQ_HZ / freq_hz;
    endfunction

    // Ceiling log2, never below 1 so a single-channel build still gets a select bit
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/div_channel.sv
// One divider channel: period counter, active/pending divisor and output shaping.
module div_channel
    import tmb_clk_pkg::*;
#(
    parameter int               CNT_W   = 28,
    parameter logic [CNT_W-1:0] RST_DIV = CNT_W'(2)
) (
    input  logic             clk40,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_mode,
    input  logic             i_restart,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_wr_val,
    output logic             o_clk_out,
    output logic             o_tick,
    output logic             o_pend
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div_act;
    logic [CNT_W-1:0] r_div_pend;
    logic             r_pend_vld;
    logic             r_clk_out;
    logic             r_tick;

    logic             w_wrap;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_half;

    // Last count of the period; divisors only change on this boundary
    assign w_wrap     = (r_cnt == (r_div_act - CNT_W'(1)));
    assign w_cnt_next = w_wrap ? '0 : (r_cnt + CNT_W'(1));
    assign w_half     = r_div_act >> 1;

    // Counter, divisor handover and registered outputs
    always_ff @(posedge clk40 or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_div_act  <= RST_DIV;
            r_div_pend <= RST_DIV;
            r_pend_vld <= 1'b0;
            r_clk_out  <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            if (i_restart || !i_en) begin
                // Park at phase 0; a held divisor can take effect right away
                r_cnt     <= '0;
                r_clk_out <= 1'b0;
                r_tick    <= 1'b0;
                if (r_pend_vld) begin
                    r_div_act  <= r_div_pend;
                    r_pend_vld <= 1'b0;
                end
            end else begin
                r_cnt     <= w_cnt_next;
                r_tick    <= w_wrap;
                r_clk_out <= (i_mode == MODE_STROBE) ? w_wrap : (w_cnt_next < w_half);
                if (w_wrap && r_pend_vld) begin
                    r_div_act  <= r_div_pend;
                    r_pend_vld <= 1'b0;
                end
            end
            // A write on the same edge wins over the clear above, so it waits for the next boundary
            if (i_wr) begin
                r_div_pend <= i_wr_val;
                r_pend_vld <= 1'b1;
            end
        end
    end

    assign o_clk_out = r_clk_out;
    assign o_tick    = r_tick;
    assign o_pend    = r_pend_vld;

endmodule

// File: rtl/multi_clock_divider.sv
// Multi-channel programmable divider of clk40 for LED blink and slow sync ticks.
module multi_clock_divider
    import tmb_clk_pkg::*;
#(
    parameter int                   NCH     = 8,
    parameter int                   CNT_W   = 28,
    parameter logic [NCH*CNT_W-1:0] DEF_DIV = {NCH{CNT_W'(1_000_000)}},
    parameter int                   MIN_DIV = MIN_DIV_DEF,
    localparam int                  CH_W    = clog2(NCH)
) (
    input  logic             clk40,
    input  logic             reset,
    input  logic [NCH-1:0]   en,
    input  logic [NCH-1:0]   mode,
    input  logic             sync_restart,
    input  logic             div_wr,
    input  logic [CH_W-1:0]  div_ch,
    input  logic [CNT_W-1:0] div_val,
    output logic             div_ack,
    output logic [NCH-1:0]   div_pend,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick
);

    localparam logic [CH_W:0]    NCH_LIM = (CH_W + 1)'(NCH);
    localparam logic [CNT_W-1:0] MIN_V   = CNT_W'(MIN_DIV);

    logic             w_wr_ok;
    logic [CNT_W-1:0] w_val_clamped;
    logic [NCH-1:0]   w_wr_ch;
    logic             r_ack;

    // Writes to channels that do not exist are dropped without an ack
    assign w_wr_ok       = div_wr && ({1'b0, div_ch} < NCH_LIM);
    assign w_val_clamped = (div_val < MIN_V) ? MIN_V : div_val;

    // Acknowledge every accepted write one edge later
    always_ff @(posedge clk40 or posedge reset) begin
        if (reset) begin
            r_ack <= 1'b0;
        end else begin
            r_ack <= w_wr_ok;
        end
    end

    assign div_ack = r_ack;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            localparam logic [CNT_W-1:0] DEF_SLICE = DEF_DIV[gi*CNT_W +: CNT_W];
            localparam logic [CNT_W-1:0] RST_DIV   = (DEF_SLICE < MIN_V) ? MIN_V : DEF_SLICE;

            assign w_wr_ch[gi] = w_wr_ok && (div_ch == CH_W'(gi));

            div_channel #(
                .CNT_W   (CNT_W),
                .RST_DIV (RST_DIV)
            ) u_ch (
                .clk40     (clk40),
                .reset     (reset),
                .i_en      (en[gi]),
                .i_mode    (mode[gi]),
                .i_restart (sync_restart),
                .i_wr      (w_wr_ch[gi]),
                .i_wr_val  (w_val_clamped),
                .o_clk_out (clk_out[gi]),
                .o_tick    (tick[gi]),
                .o_pend    (div_pend[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_multi_clock_divider.sv
// Self-checking bench for multi_clock_divider against a period-arithmetic model.
module tb_multi_clock_divider;

    localparam int NCH     = 5;
    localparam int CNT_W   = 28;
    localparam int CH_W    = 3;
    localparam int MIN_DIV = 2;
    // ch0=4, ch1=5, ch2=2, ch3=1 (clamps to 2), ch4=3
    localparam logic [NCH*CNT_W-1:0] DEF_DIV = {28'd3, 28'd1, 28'd2, 28'd5, 28'd4};

    logic             clk40 = 1'b0;
    logic             reset = 1'b1;
    logic [NCH-1:0]   en = '0;
    logic [NCH-1:0]   mode = '0;
    logic             sync_restart = 1'b0;
    logic             div_wr = 1'b0;
    logic [CH_W-1:0]  div_ch = '0;
    logic [CNT_W-1:0] div_val = '0;
    logic             div_ack;
    logic [NCH-1:0]   div_pend;
    logic [NCH-1:0]   clk_out;
    logic [NCH-1:0]   tick;

    int total = 0;
    int bad   = 0;

    // Model: edges elapsed since the current divisor epoch began, plus divisors
    int             m_t  [NCH];
    int             m_d  [NCH];
    int             m_p  [NCH];
    bit             m_pv [NCH];
    logic [NCH-1:0] e_clk, e_tick, e_pend;
    logic           e_ack;

    multi_clock_divider #(
        .NCH     (NCH),
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV),
        .MIN_DIV (MIN_DIV)
    ) dut (
        .clk40        (clk40),
        .reset        (reset),
        .en           (en),
        .mode         (mode),
        .sync_restart (sync_restart),
        .div_wr       (div_wr),
        .div_ch       (div_ch),
        .div_val      (div_val),
        .div_ack      (div_ack),
        .div_pend     (div_pend),
        .clk_out      (clk_out),
        .tick         (tick)
    );

    always #5 clk40 = ~clk40;

    function automatic int clamp_div(input int v);
        return (v < MIN_DIV) ? MIN_DIV : v;
    endfunction

    task automatic model_reset();
        logic [NCH*CNT_W-1:0] defs;
        defs = DEF_DIV;
        for (int i = 0; i < NCH; i++) begin
            m_t[i]  = 0;
            m_d[i]  = clamp_div(int'(defs[i*CNT_W +: CNT_W]));
            m_pv[i] = 1'b0;
        end
        e_clk = '0; e_tick = '0; e_pend = '0; e_ack = 1'b0;
    endtask

    // Within an epoch of divisor D: every D-th edge ends a period (tick);
    // square output is high for the first floor(D/2) positions of each period.
    task automatic model_edge();
        int ph;
        for (int i = 0; i < NCH; i++) begin
            if (sync_restart || !en[i]) begin
                m_t[i] = 0; e_clk[i] = 1'b0; e_tick[i] = 1'b0;
                if (m_pv[i]) begin m_d[i] = m_p[i]; m_pv[i] = 1'b0; end
            end else begin
                m_t[i]++;
                ph = m_t[i] % m_d[i];
                e_tick[i] = (ph == 0);
                e_clk[i]  = mode[i] ? (ph == 0) : (ph < m_d[i] / 2);
                if (ph == 0 && m_pv[i]) begin
                    m_d[i] = m_p[i]; m_pv[i] = 1'b0; m_t[i] = 0;
                end
            end
        end
        e_ack = div_wr && (int'(div_ch) < NCH);
        if (e_ack) begin
            m_p[div_ch]  = clamp_div(int'(div_val));
            m_pv[div_ch] = 1'b1;
        end
        for (int i = 0; i < NCH; i++) e_pend[i] = m_pv[i];
    endtask

    // Advance one clock; model follows the same inputs, outputs sampled 1 ns later
    task automatic step();
        @(posedge clk40);
        model_edge();
        #1;
    endtask

    task automatic drive_write(input int ch, input int val);
        div_wr  = 1'b1;
        div_ch  = CH_W'(ch);
        div_val = CNT_W'(val);
        $display("write ch=%0d val=%0d t=%0t", ch, val, $time);
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        if ({div_ack, div_pend, tick, clk_out} !== '0) begin
            bad++;
            $display("FAIL reset_state got=%b_%b_%b_%b required=all zero", div_ack, div_pend, tick, clk_out);
        end
        total++;
        @(negedge clk40);
        en = '1;
        reset = 1'b0;
    endtask

    task automatic test_default_periods();
        for (int c = 0; c < 40; c++) begin
            step();
            if ({div_ack, div_pend, tick, clk_out} !== {e_ack, e_pend, e_tick, e_clk}) begin
                bad++;
                $display("FAIL default_periods cyc=%0d got=%b_%b_%b_%b exp=%b_%b_%b_%b", c,
                         div_ack, div_pend, tick, clk_out, e_ack, e_pend, e_tick, e_clk);
            end
            total++;
            // ch3 default clamps to 2, so it must mirror ch2
            if (clk_out[3] !== clk_out[2]) begin
                bad++;
                $display("FAIL clamp_default cyc=%0d got=%b required=%b", c, clk_out[3], clk_out[2]);
            end
            total++;
        end
    endtask

    task automatic test_div_write();
        int k;
        k = 0;
        while (k < 20 && (m_t[0] % m_d[0]) != 1) begin
            step();
            if ({div_ack, div_pend, tick, clk_out} !== {e_ack, e_pend, e_tick, e_clk}) begin
                bad++;
                $display("FAIL div_write_align got=%b_%b_%b_%b exp=%b_%b_%b_%b",
                         div_ack, div_pend, tick, clk_out, e_ack, e_pend, e_tick, e_clk);
            end
            total++;
            k++;
        end
        if (k >= 20) begin
            bad++;
            $display("FAIL div_write_timeout got=%0d cycles required<20", k);
        end
        drive_write(0, 6);
        step();
        div_wr = 1'b0;
        if (div_ack !== 1'b1 || div_pend[0] !== 1'b1) begin
            bad++;
            $display("FAIL div_write_ack got=ack%b pend%b required=ack1 pend1", div_ack, div_pend[0]);
        end
        total++;
        for (int c = 0; c < 30; c++) begin
            step();
            if ({div_ack, div_pend, tick, clk_out} !== {e_ack, e_pend, e_tick, e_clk}) begin
                bad++;
                $display("FAIL div_write cyc=%0d got=%b_%b_%b_%b exp=%b_%b_%b_%b", c,
                         div_ack, div_pend, tick, clk_out, e_ack, e_pend, e_tick, e_clk);
            end
            total++;
        end
    endtask

    task automatic test_overwrite_and_bad_ch();
        drive_write(1, 8);
        step();
        drive_write(1, 3);
        step();
        drive_write(5, 9);
        step();
        div_wr = 1'b0;
        if (div_ack !== 1'b0) begin
            bad++;
            $display("FAIL bad_ch_ack got=%b required=0", div_ack);
        end
        total++;
        for (int c = 0; c < 30; c++) begin
            step();
            if ({div_ack, div_pend, tick, clk_out} !== {e_ack, e_pend, e_tick, e_clk}) begin
                bad++;
                $display("FAIL overwrite cyc=%0d got=%b_%b_%b_%b exp=%b_%b_%b_%b", c,
                         div_ack, div_pend, tick, clk_out, e_ack, e_pend, e_tick, e_clk);
            end
            total++;
        end
    endtask

    task automatic test_sync_restart();
        drive_write(0, 4);
        step();
        drive_write(1, 6);
        step();
        div_wr = 1'b0;
        repeat (13) step();
        sync_restart = 1'b1;
        step();
        sync_restart = 1'b0;
        if (clk_out[1:0] !== 2'b00 || tick[1:0] !== 2'b00) begin
            bad++;
            $display("FAIL restart_zero got=clk%b tick%b required=00", clk_out[1:0], tick[1:0]);
        end
        total++;
        for (int c = 0; c < 36; c++) begin
            step();
            if ({div_ack, div_pend, tick, clk_out} !== {e_ack, e_pend, e_tick, e_clk}) begin
                bad++;
                $display("FAIL sync_restart cyc=%0d got=%b_%b_%b_%b exp=%b_%b_%b_%b", c,
                         div_ack, div_pend, tick, clk_out, e_ack, e_pend, e_tick, e_clk);
            end
            total++;
        end
    endtask

    task automatic test_strobe();
        mode[2] = 1'b1;
        drive_write(2, 5);
        step();
        div_wr = 1'b0;
        for (int c = 0; c < 25; c++) begin
            step();
            if ({div_ack, div_pend, tick, clk_out} !== {e_ack, e_pend, e_tick, e_clk}) begin
                bad++;
                $display("FAIL strobe cyc=%0d got=%b_%b_%b_%b exp=%b_%b_%b_%b", c,
                         div_ack, div_pend, tick, clk_out, e_ack, e_pend, e_tick, e_clk);
            end
            total++;
            if (clk_out[2] !== tick[2]) begin
                bad++;
                $display("FAIL strobe_eq_tick cyc=%0d got=%b required=%b", c, clk_out[2], tick[2]);
            end
            total++;
        end
        mode[2] = 1'b0;
    endtask

    task automatic test_enable();
        repeat (2) step();
        en[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (clk_out[0] !== 1'b0 || tick[0] !== 1'b0) begin
                bad++;
                $display("FAIL enable_low cyc=%0d got=clk%b tick%b required=0 0", c, clk_out[0], tick[0]);
            end
            total++;
        end
        en[0] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            if ({div_ack, div_pend, tick, clk_out} !== {e_ack, e_pend, e_tick, e_clk}) begin
                bad++;
                $display("FAIL enable cyc=%0d got=%b_%b_%b_%b exp=%b_%b_%b_%b", c,
                         div_ack, div_pend, tick, clk_out, e_ack, e_pend, e_tick, e_clk);
            end
            total++;
        end
    endtask

    task automatic test_async_reset();
        drive_write(4, 7);
        step();
        div_wr = 1'b0;
        step();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        if ({div_ack, div_pend, tick, clk_out} !== '0) begin
            bad++;
            $display("FAIL async_reset got=%b_%b_%b_%b required=all zero", div_ack, div_pend, tick, clk_out);
        end
        total++;
        @(negedge clk40);
        reset = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step();
            if ({div_ack, div_pend, tick, clk_out} !== {e_ack, e_pend, e_tick, e_clk}) begin
                bad++;
                $display("FAIL post_reset cyc=%0d got=%b_%b_%b_%b exp=%b_%b_%b_%b", c,
                         div_ack, div_pend, tick, clk_out, e_ack, e_pend, e_tick, e_clk);
            end
            total++;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(15) == 0) en[i] = ~en[i];
                if ($urandom_range(63) == 0) mode[i] = ~mode[i];
            end
            sync_restart = ($urandom_range(39) == 0);
            if ($urandom_range(5) == 0) begin
                drive_write(int'($urandom_range(7)), int'($urandom_range(9)));
            end else begin
                div_wr = 1'b0;
            end
            step();
            if ({div_ack, div_pend, tick, clk_out} !== {e_ack, e_pend, e_tick, e_clk}) begin
                bad++;
                $display("FAIL random cyc=%0d got=%b_%b_%b_%b exp=%b_%b_%b_%b", c,
                         div_ack, div_pend, tick, clk_out, e_ack, e_pend, e_tick, e_clk);
            end
            total++;
        end
        div_wr = 1'b0;
        sync_restart = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default_periods();
        test_div_write();
        test_overwrite_and_bad_ch();
        test_sync_restart();
        test_strobe();
        test_enable();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_clock_divider.md
Name: multi_clock_divider

Overview:
- Parametrised, multi-channel successor to the single-divisor 40 MHz clock divider that drives front-panel LEDs and slow sync ticks on the TMB emulator.
- Each of NCH channels divides clk40 by a runtime-programmable divisor.
- Each channel outputs either a square wave (LED blink) or a one-cycle strobe (slow sync tick).
- Provides per-channel enable, a global phase-aligning restart, and glitch-free divisor updates applied only at period boundaries.

Parameters:
- NCH, 8, number of channels.
- CNT_W, 28, counter/divisor width.
- DEF_DIV, {NCH{28'd1_000_000}}, packed per-channel reset divisors; channel i is DEF_DIV[i*CNT_W +: CNT_W].
- MIN_DIV, 2, smallest legal divisor; smaller values are clamped up to it.

Ports:
- clk40  in  1  40 MHz system clock; sole clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  NCH  per-channel enable.
- mode  in  NCH  per channel: 0 = square wave, 1 = strobe.
- sync_restart  in  1  one-cycle pulse that realigns all channels to phase 0.
- div_wr  in  1  divisor write strobe.
- div_ch  in  clog2(NCH)  target channel for the write.
- div_val  in  CNT_W  new divisor value.
- div_ack  out  1  one-cycle pulse confirming an accepted write.
- div_pend  out  NCH  high while a channel holds an unapplied divisor.
- clk_out  out  NCH  divided output (square wave or strobe, per mode).
- tick  out  NCH  one-cycle pulse at the start of every period.

Behaviour:
- Reset (asynchronous):
  - cnt = 0, clk_out = 0, tick = 0, div_ack = 0, div_pend = 0.
  - div_act[i] = max(DEF_DIV slice, MIN_DIV).
- Priority per channel, per edge: reset > sync_restart > en low > normal count.
- Normal count (en = 1):
  - cnt_next = (cnt == div_act-1) ? 0 : cnt+1.
  - tick <= (cnt == div_act-1).
  - Square mode: clk_out <= (cnt_next < div_act>>1). High time = floor(D/2), low time = ceil(D/2), period exactly D cycles.
  - Strobe mode: clk_out <= (cnt == div_act-1), i.e. identical to tick.
- Period example, D = 4, square mode, from reset release: cnt 1,2,3,0,1,... ; clk_out 1,0,0,1,1,0,0,1... ; tick high only in cycles where cnt = 0 after a wrap. No tick is produced on reset release.
- en low: cnt <= 0, clk_out <= 0, tick <= 0 on the next edge. A pending divisor is applied immediately. On re-enable, behaviour is identical to release from reset.
- sync_restart: every channel gets cnt <= 0, clk_out <= 0, tick <= 0, and any pending divisor is applied. After it, all enabled channels with equal divisors are exactly phase-aligned.
- Divisor write:
  - On div_wr with div_ch < NCH: pend[div_ch] <= max(div_val, MIN_DIV), div_pend[div_ch] <= 1, and div_ack pulses for one cycle on the next edge.
  - div_ch >= NCH: write ignored, no ack.
  - Apply: on the wrap edge (cnt == div_act-1, en = 1), div_act <= pend and div_pend clears.
  - Write on the same edge as a wrap: the previously pending value, if any, is applied; the new value is stored and applied at the next wrap.
  - A second write before apply overwrites the pending value; only the last value is used.
  - sync_restart and a write in the same cycle: the old pending value is applied, the new write is stored as pending.
- Reset asserted mid-period: outputs drop asynchronously. Pending writes are lost and div_act returns to its DEF_DIV value.
- All outputs are registered; no combinational path from input to output.

Decomposition:
- Shared package tmb_clk_pkg holds:
  - MODE_SQUARE = 1'b0 and MODE_STROBE = 1'b1.
  - MIN_DIV default.
  - a clog2 function.
  - the 40 MHz base-frequency constant used to derive LED and sync divisors.
- Sub-module div_channel: one channel's counter, active/pending divisor registers and output logic, instantiated NCH times by a generate loop.
- The top level holds write decode, clamping and div_ack.

Test Plan:
- NCH = 4, DEF_DIV = {4,5,2,1}, all en = 1, mode = 0 → ch0 period 4 (high 2); ch1 period 5 (high 2, low 3); ch2 toggles every cycle; ch3 clamped to 2 and identical to ch2. Ticks every 4/5/2/2 cycles.
- ch0 D = 4. Write div_val = 6 to ch0 when cnt = 1 → div_ack one cycle later, div_pend[0] = 1. Current 4-cycle period completes unchanged, then period becomes 6 and div_pend clears.
- Write ch1 = 8, then ch1 = 3 before the wrap → only 3 is applied. Write div_ch = 5 → no ack, no state change.
- Channels with D = 4 and D = 6 free-running, pulse sync_restart → both clk_out = 0 next cycle, then rise together. Ticks coincide every 12 cycles.
- mode[2] = 1, D = 5 → clk_out[2] equals tick[2]: a single-cycle pulse every 5 cycles.
- en[0] low for 3 cycles mid-period, then high → outputs 0 while disabled; sequence after re-enable matches post-reset. Assert reset asynchronously mid-cycle → all outputs 0 immediately and div_act returns to DEF_DIV.
